xf100_exu_wbck_arb: RTL and testbench
=====================================

XF100_EXU_WBCK_ARB -- requirements
Module: xf100_exu_wbck_arb

Interface
REQ-001 SHALL have parameter NCH, default 4 (legal 2..8), meaning number of writeback source channels.
REQ-002 SHALL have parameter XLEN, default `XF100_XLEN, meaning writeback data width.
REQ-003 SHALL have parameter RFIDX_W, default `XF100_RFIDX_WIDTH, meaning register index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wbck_i_valid, input, NCH bits: per-channel writeback request.
REQ-007 SHALL have port wbck_i_ready, output, NCH bits: per-channel acceptance.
REQ-008 SHALL have port wbck_i_data, input, NCH*XLEN bits: channel i occupies bits [i*XLEN +: XLEN].
REQ-009 SHALL have port wbck_i_rdidx, input, NCH*RFIDX_W bits: channel i occupies bits [i*RFIDX_W +: RFIDX_W].
REQ-010 SHALL have port wbck_o_valid, output, 1 bit: registered regfile write enable.
REQ-011 SHALL have port wbck_o_ready, input, 1 bit: regfile write port accepts.
REQ-012 SHALL have port wbck_o_data, output, XLEN bits: registered write data.
REQ-013 SHALL have port wbck_o_rdidx, output, RFIDX_W bits: registered destination index.

Function
REQ-014 SHALL transfer on a channel when valid[i] and ready[i] are both 1 in the same cycle, and on the output when o_valid and o_ready are both 1.
REQ-015 SHALL hold one output entry; the slot is free when o_valid=0 or o_ready=1.
REQ-016 SHALL grant at most one channel with rdidx!=0 per cycle, and only when the slot is free; ready[i]=grant[i].
REQ-017 SHALL load the granted channel's data and rdidx into the output register and set o_valid=1 on the next edge: latency is exactly 1 cycle, with full throughput of 1 write per cycle while o_ready=1.
REQ-018 SHALL clear o_valid on an output transfer with no new grant, and SHALL keep data and rdidx stable while o_valid=1 and o_ready=0.
REQ-019 SHALL treat a channel with valid=1 and rdidx=0 (x0) as a discard: ready=1 in the same cycle regardless of slot state, with no arbitration and no output write.
REQ-020 SHALL support any number of simultaneous x0 discards plus one granted write in the same cycle.
REQ-021 SHALL make ready[i] a function of the current valid, rdidx, pointer and slot state only, with no dependence on data.
REQ-022 SHALL never drop or duplicate a non-x0 request; an ungranted channel waits with ready=0.

Reset
REQ-023 SHALL, while rst=1, drive o_valid=0, o_data=0, o_rdidx=0 and ready=0 on all channels (including x0 requests), and set the priority pointer to 0.
REQ-024 SHALL discard an entry held in the output register when reset is asserted mid-operation, with no write reported.

Configuration
REQ-025 SHALL, with macro XF100_WBCK_RR_EN defined, arbitrate round-robin: search starts at pointer p; after a grant to channel g the pointer becomes (g+1) mod NCH; the pointer holds when there is no grant.
REQ-026 SHALL, without XF100_WBCK_RR_EN, use fixed priority with the lowest index winning and no pointer register.

Structure
REQ-027 SHALL place `XF100_WBCK_NCH (default 4) in xf100_defines.v, alongside the existing XLEN and RFIDX defines.
REQ-028 SHALL implement arbitration in one sub-module, xf100_rr_arb (request vector in, one-hot grant out, pointer register under XF100_WBCK_RR_EN); the output register stays in the top level.

Verification
REQ-029 SHALL cover single write: ch1 valid, rdidx=5, data=0xDEAD_BEEF, o_ready=1 -> ready[1]=1 the same cycle; next cycle o_valid=1, rdidx=5, data=0xDEADBEEF.
REQ-030 SHALL cover round-robin contention (RR_EN, NCH=4): all channels valid with rdidx 1..4 held for 4 cycles -> grants in order 0,1,2,3, then back to 0.
REQ-031 SHALL cover fixed priority (no RR_EN): ch0 and ch2 valid continuously -> ch0 granted every cycle and ch2 starved with ready[2]=0.
REQ-032 SHALL cover backpressure: o_valid=1 with rdidx=7 and o_ready=0 for 3 cycles while ch3 is valid -> output stable, ready[3]=0; when o_ready=1, ch3 is granted the same cycle.
REQ-033 SHALL cover x0 discard: ch0 rdidx=0 and ch1 rdidx=9, both valid, with o_valid=1 and o_ready=0 -> ready[0]=1, ready[1]=0, no write of index 0 ever appears.
REQ-034 SHALL cover mid-operation reset: rst pulsed for 1 cycle while o_valid=1 -> the next cycle shows o_valid=0 and pointer=0, and the next grant goes to the lowest valid channel.

Source files
------------

// File: rtl/xf100_exu_wbck_arb_pkg.sv
// Shared types and helpers for the EXU writeback arbiter. Also provides fallback
// defaults for the xf100_defines.v macros. XF100_WBCK_RR_EN selects round-robin arbitration.
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif
`ifndef XF100_WBCK_NCH
`define XF100_WBCK_NCH 4
`endif

package xf100_exu_wbck_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

`ifdef XF100_WBCK_RR_EN
   localparam arb_mode_e ARB_MODE = ARB_RR;
`else
   localparam arb_mode_e ARB_MODE = ARB_FIXED;
`endif

   localparam int NCH_MIN = 2;
   localparam int NCH_MAX = 8;

   // Width of a pointer that names one of n channels (never zero bits).
   function automatic int ptr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Channel after v, wrapping at n; v may exceed n-1 by up to n-1.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1) % n;
   endfunction

endpackage

// File: rtl/xf100_rr_arb.sv
// One-hot request arbiter: round-robin with a rotating pointer under
// XF100_WBCK_RR_EN, otherwise fixed priority with the lowest index winning.
module xf100_rr_arb
   import xf100_exu_wbck_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant,
   output logic         o_any
);

`ifdef XF100_WBCK_RR_EN
   localparam int PW = ptr_w(N);

   logic [PW-1:0]  r_ptr;
   logic [PW-1:0]  w_ptr_nxt;
   logic [2*N-1:0] w_req_dbl;
   logic [2*N-1:0] w_gnt_dbl;
   logic [N-1:0]   w_req_rot;
   logic [N-1:0]   w_gnt_rot;

   // Rotate requests so that the pointer channel sits at bit 0, pick the
   // lowest rotated request, then rotate the grant back.
   assign w_req_dbl = {i_req, i_req} >> r_ptr;
   assign w_req_rot = w_req_dbl[N-1:0];

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      w_gnt_rot = '0;
      w_ptr_nxt = r_ptr;
      if (i_en) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
               w_gnt_rot    = '0;
               w_gnt_rot[k] = 1'b1;
               w_ptr_nxt    = PW'(wrap_inc(int'(r_ptr) + k, N));
            end
         end
      end
   end

   assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << r_ptr;
   assign o_grant   = w_gnt_dbl[2*N-1:N];
   assign o_any     = |w_gnt_rot;

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (|w_gnt_rot) begin
         r_ptr <= w_ptr_nxt;
      end
   end
`else
   logic [N-1:0] w_grant;
   logic         w_unused_clk_rst;

   // Fixed priority keeps no state.
   assign w_unused_clk_rst = clk ^ rst;

   always_comb begin
      w_grant = '0;
      if (i_en) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
               w_grant    = '0;
               w_grant[k] = 1'b1;
            end
         end
      end
   end

   assign o_grant = w_grant;
   assign o_any   = |w_grant;
`endif

endmodule

// File: rtl/xf100_exu_wbck_arb.sv
// EXU writeback arbiter: merges NCH writeback channels into one registered regfile
// write port; x0 writes are acknowledged and dropped. XF100_WBCK_RR_EN selects round-robin.
module xf100_exu_wbck_arb
   import xf100_exu_wbck_arb_pkg::*;
#(
   parameter int NCH     = `XF100_WBCK_NCH,
   parameter int XLEN    = `XF100_XLEN,
   parameter int RFIDX_W = `XF100_RFIDX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         wbck_i_valid,
   output logic [NCH-1:0]         wbck_i_ready,
   input  logic [NCH*XLEN-1:0]    wbck_i_data,
   input  logic [NCH*RFIDX_W-1:0] wbck_i_rdidx,
   output logic                   wbck_o_valid,
   input  logic                   wbck_o_ready,
   output logic [XLEN-1:0]        wbck_o_data,
   output logic [RFIDX_W-1:0]     wbck_o_rdidx
);

   logic               r_valid;
   logic [XLEN-1:0]    r_data;
   logic [RFIDX_W-1:0] r_rdidx;

   logic [NCH-1:0]     w_req;
   logic [NCH-1:0]     w_x0;
   logic [NCH-1:0]     w_grant;
   logic               w_any;
   logic               w_slot_free;
   logic               w_arb_en;
   logic [XLEN-1:0]    w_sel_data;
   logic [RFIDX_W-1:0] w_sel_rdidx;

   // Split valid requests into real writes and x0 discards; only writes arbitrate.
   always_comb begin
      w_req = '0;
      w_x0  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (wbck_i_valid[i]) begin
            if (wbck_i_rdidx[i*RFIDX_W +: RFIDX_W] == '0) begin
               w_x0[i] = 1'b1;
            end else begin
               w_req[i] = 1'b1;
            end
         end
      end
   end

   assign w_slot_free = ~r_valid | wbck_o_ready;
   assign w_arb_en    = w_slot_free & ~rst;

   xf100_rr_arb #(
      .N (NCH)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_arb_en),
      .i_req   (w_req),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   // One-hot AND-OR select of the granted channel.
   always_comb begin
      w_sel_data  = '0;
      w_sel_rdidx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) begin
            w_sel_data  = w_sel_data  | wbck_i_data[i*XLEN +: XLEN];
            w_sel_rdidx = w_sel_rdidx | wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
         end
      end
   end

   assign wbck_i_ready = rst ? '0 : (w_grant | w_x0);

   // The slot reloads whenever it is free; an ungranted free slot goes empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_rdidx <= '0;
      end else if (w_slot_free) begin
         r_valid <= w_any;
         if (w_any) begin
            r_data  <= w_sel_data;
            r_rdidx <= w_sel_rdidx;
         end
      end
   end

   // Outputs read as zero for the whole reset window, including its first cycle.
   assign wbck_o_valid = r_valid & ~rst;
   assign wbck_o_data  = rst ? '0 : r_data;
   assign wbck_o_rdidx = rst ? '0 : r_rdidx;

endmodule

// File: tb/tb_xf100_exu_wbck_arb.sv
// Self-checking bench for xf100_exu_wbck_arb: directed scenarios then random traffic,
// checked against a slot/pointer model and an in-order write scoreboard.
module tb_xf100_exu_wbck_arb;

   localparam int NCH = 4;
   localparam int XLEN = 32;
   localparam int RW = 5;
`ifdef XF100_WBCK_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      i_valid;
   logic [NCH-1:0]      i_ready;
   logic [NCH*XLEN-1:0] i_data;
   logic [NCH*RW-1:0]   i_rdidx;
   logic                o_valid;
   logic                o_ready;
   logic [XLEN-1:0]     o_data;
   logic [RW-1:0]       o_rdidx;

   always #5 clk = ~clk;

   xf100_exu_wbck_arb #(
      .NCH     (NCH),
      .XLEN    (XLEN),
      .RFIDX_W (RW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wbck_i_valid (i_valid),
      .wbck_i_ready (i_ready),
      .wbck_i_data  (i_data),
      .wbck_i_rdidx (i_rdidx),
      .wbck_o_valid (o_valid),
      .wbck_o_ready (o_ready),
      .wbck_o_data  (o_data),
      .wbck_o_rdidx (o_rdidx)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: one output slot plus the round-robin start channel.
   bit              m_valid;
   logic [XLEN-1:0] m_data;
   logic [RW-1:0]   m_rdidx;
   int              m_ptr;
   int              cur_g;

   typedef struct {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] d;
   } wr_t;
   wr_t sb_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] rd_of(input int i);
      return i_rdidx[i*RW +: RW];
   endfunction

   function automatic logic [XLEN-1:0] data_of(input int i);
      return i_data[i*XLEN +: XLEN];
   endfunction

   // Channel that should win this cycle, or -1.
   function automatic int exp_grant();
      int idx;
      if (rst || !(!m_valid || o_ready)) return -1;
      for (int k = 0; k < NCH; k++) begin
         idx = RR ? (m_ptr + k) % NCH : k;
         if (i_valid[idx] && rd_of(idx) != '0) return idx;
      end
      return -1;
   endfunction

   task automatic set_ch(input int i, input logic v, input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
      i_valid[i]            = v;
      i_rdidx[i*RW +: RW]   = rd;
      i_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic clear_inputs();
      i_valid = '0;
      i_rdidx = '0;
      i_data  = '0;
   endtask

   // Sample after inputs settle, compare every output with the model.
   task automatic sample(input string tag);
      logic [NCH-1:0] er;
      wr_t w;
      #1;
      cur_g = exp_grant();
      er = '0;
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            if (i_valid[i] && rd_of(i) == '0) er[i] = 1'b1;
         end
      end
      if (cur_g >= 0) er[cur_g] = 1'b1;
      check({tag, "/ready"}, i_ready, er);
      check({tag, "/o_valid"}, o_valid, (rst ? 1'b0 : m_valid));
      if (rst || m_valid) begin
         check({tag, "/o_data"}, o_data, (rst ? '0 : m_data));
         check({tag, "/o_rdidx"}, o_rdidx, (rst ? '0 : m_rdidx));
      end
      if (o_valid) check({tag, "/x0_write"}, (o_rdidx == '0), 1'b0);
      if (rst) begin
         sb_q.delete();
      end else begin
         if (o_valid && o_ready) begin
            if (sb_q.size() == 0) begin
               check({tag, "/sb_unexpected_write"}, 1'b1, 1'b0);
            end else begin
               w = sb_q.pop_front();
               check({tag, "/sb_rdidx"}, o_rdidx, w.rd);
               check({tag, "/sb_data"}, o_data, w.d);
            end
         end
         if (cur_g >= 0) sb_q.push_back('{rd: rd_of(cur_g), d: data_of(cur_g)});
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_rdidx = '0;
         m_ptr   = 0;
      end else if (!m_valid || o_ready) begin
         if (cur_g >= 0) begin
            m_valid = 1'b1;
            m_data  = data_of(cur_g);
            m_rdidx = rd_of(cur_g);
            m_ptr   = (cur_g + 1) % NCH;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [NCH-1:0] acc;
      int exp_ch;

      m_valid = 1'b0; m_data = '0; m_rdidx = '0; m_ptr = 0; cur_g = -1;
      rst = 1'b1; o_ready = 1'b0; clear_inputs();
      set_ch(0, 1'b1, 5'd0, 32'h1111);
      set_ch(2, 1'b1, 5'd3, 32'h2222);
      sample("reset"); advance();
      sample("reset2"); advance();

      // Single write on channel 1
      rst = 1'b0; clear_inputs(); o_ready = 1'b1;
      set_ch(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      sample("single");
      check("single/ready1_same_cycle", i_ready[1], 1'b1);
      advance();
      clear_inputs();
      sample("single_out");
      check("single/o_valid", o_valid, 1'b1);
      check("single/o_rdidx", o_rdidx, 5'd5);
      check("single/o_data", o_data, 32'hDEAD_BEEF);
      advance();
      sample("single_drain");
      check("single/cleared", o_valid, 1'b0);
      advance();

      // Contention from a fresh pointer: all channels hold rdidx 1..4
      rst = 1'b1; sample("ptr_reset"); advance(); rst = 1'b0;
      for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, RW'(i + 1), 32'h100 + i);
      for (int k = 0; k < 5; k++) begin
         sample("contend");
         exp_ch = RR ? (k % NCH) : 0;
         check("contend/grant_order", i_ready, (4'b0001 << exp_ch));
         advance();
      end

      // Two persistent requesters on channels 0 and 2
      clear_inputs();
      set_ch(0, 1'b1, 5'd1, 32'hA0);
      set_ch(2, 1'b1, 5'd3, 32'hA2);
      for (int k = 0; k < 3; k++) begin
         sample("pair");
`ifdef XF100_WBCK_RR_EN
         check("pair/rr_alternate", i_ready, ((k % 2 == 0) ? 4'b0100 : 4'b0001));
`else
         check("pair/ch0_wins", i_ready[0], 1'b1);
         check("pair/ch2_starved", i_ready[2], 1'b0);
`endif
         advance();
      end

      // Backpressure on an entry with rdidx 7
      clear_inputs(); o_ready = 1'b1;
      set_ch(0, 1'b1, 5'd7, 32'h7777);
      sample("bp_load"); advance();
      clear_inputs(); o_ready = 1'b0;
      set_ch(3, 1'b1, 5'd12, 32'hC0C0);
      for (int k = 0; k < 3; k++) begin
         sample("bp_hold");
         check("bp/o_valid", o_valid, 1'b1);
         check("bp/o_rdidx_stable", o_rdidx, 5'd7);
         check("bp/o_data_stable", o_data, 32'h7777);
         check("bp/ch3_waits", i_ready[3], 1'b0);
         advance();
      end
      o_ready = 1'b1;
      sample("bp_release");
      check("bp/ch3_granted_same_cycle", i_ready[3], 1'b1);
      advance();

      // x0 discard while the slot is full and stalled
      clear_inputs(); o_ready = 1'b0;
      set_ch(0, 1'b1, 5'd0, 32'hAAAA);
      set_ch(1, 1'b1, 5'd9, 32'h9999);
      for (int k = 0; k < 2; k++) begin
         sample("x0");
         check("x0/ready", i_ready, 4'b0001);
         check("x0/slot_kept", o_rdidx, 5'd12);
         advance();
      end

      // Reset pulse with a held entry
      rst = 1'b1;
      sample("mid_rst"); advance();
      rst = 1'b0; clear_inputs(); o_ready = 1'b1;
      set_ch(1, 1'b1, 5'd3, 32'h3333);
      set_ch(3, 1'b1, 5'd4, 32'h4444);
      sample("after_rst");
      check("rst/o_valid_cleared", o_valid, 1'b0);
      check("rst/lowest_wins", i_ready, 4'b0010);
      advance();
      clear_inputs();
      sample("after_rst_out");
      check("rst/o_rdidx", o_rdidx, 5'd3);
      advance();

      // Random traffic: sources hold each request until it is accepted
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 79) == 0);
         o_ready = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < NCH; i++) begin
            if (!i_valid[i] && $urandom_range(0, 1) == 1) begin
               set_ch(i, 1'b1, (($urandom_range(0, 3) == 0) ? 5'd0 : RW'($urandom_range(1, 31))), $urandom);
            end
         end
         sample("rand");
         acc = i_valid & i_ready;
         advance();
         for (int i = 0; i < NCH; i++) begin
            if (acc[i]) set_ch(i, 1'b0, 5'd0, 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
